reg_bus_sched: RTL and testbench

- Sequences transfers between the 8-bit registers that share the CPU internal tristate data bus.
- Each register block exposes an output enable (oe) and a rising-edge latch input.
- Queues transfer commands (one source, one or more destinations) and drives exactly one oe and the selected latch strobes with a contention-free drive/latch/hold sequence.
- Sits between the instruction decoder and the register file.

---
 rtl/reg_bus_sched.sv | 151 +++++++++++++++
 tb/tb_reg_bus_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_sched.sv
// Internal-bus transfer scheduler: queues {src, dst} commands and runs a
// contention-free DRIVE/LATCH/HOLD sequence. Define REG_BUS_SCHED_PRECHARGE_EN for a bus-float cycle after HOLD.
module reg_bus_sched #(
  parameter int NREG  = 8,
  parameter int SW    = 3,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SW-1:0]   cmd_src,
  input  logic [NREG-1:0] cmd_dst,
  output logic [NREG-1:0] oe,
  output logic [NREG-1:0] latch,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
`ifdef REG_BUS_SCHED_PRECHARGE_EN
  localparam logic [2:0] S_PRE   = 3'd4;
`endif

  logic [SW-1:0]   mem_src [DEPTH];
  logic [NREG-1:0] mem_dst [DEPTH];
  logic [AW:0]     wp, rp, wp_n, rp_n;

  logic [2:0]      state, state_n;
  logic            pend, pend_n;
  logic [SW-1:0]   cur_src, cur_src_n;
  logic [NREG-1:0] cur_dst, cur_dst_n;

  logic            push, pop, pop_slot, empty, empty_n, full_n;
  logic            head_bad, src_oor, err_n, active_n;
  logic [SW-1:0]   head_src;
  logic [NREG-1:0] head_dst;
  logic [NREG-1:0] oe_n, latch_n;

  assign empty    = (wp == rp);
  assign push     = cmd_valid && cmd_ready;
  assign head_src = mem_src[rp[AW-1:0]];
  assign head_dst = mem_dst[rp[AW-1:0]];

  if (NREG < (1 << SW)) begin : g_src_chk
    assign src_oor = (32'(head_src) >= NREG);
  end else begin : g_src_full
    assign src_oor = 1'b0;
  end

  assign head_bad = src_oor || (head_dst == '0) ||
                    ((head_dst & (NREG'(1) << head_src)) != '0);

  always_comb begin
    state_n   = state;
    pend_n    = pend;
    cur_src_n = cur_src;
    cur_dst_n = cur_dst;
    err_n     = 1'b0;

    // A command is popped into the staging register on the edge that ends
    // IDLE-without-work or the last cycle of a transfer; IDLE then launches it.
`ifdef REG_BUS_SCHED_PRECHARGE_EN
    pop_slot = ((state == S_IDLE) && !pend) || (state == S_PRE);
`else
    pop_slot = ((state == S_IDLE) && !pend) || (state == S_HOLD);
`endif
    pop = pop_slot && !empty;

    case (state)
      S_IDLE: begin
        if (pend) begin
          state_n = S_DRIVE;
          pend_n  = 1'b0;
        end
      end
      S_DRIVE: state_n = S_LATCH;
      S_LATCH: state_n = S_HOLD;
`ifdef REG_BUS_SCHED_PRECHARGE_EN
      S_HOLD:  state_n = S_PRE;
      S_PRE:   state_n = S_IDLE;
`else
      S_HOLD:  state_n = S_IDLE;
`endif
      default: state_n = S_IDLE;
    endcase

    if (pop) begin
      if (head_bad) begin
        err_n = 1'b1;
      end else begin
        pend_n    = 1'b1;
        cur_src_n = head_src;
        cur_dst_n = head_dst;
      end
    end

    wp_n    = wp + (AW+1)'(push);
    rp_n    = rp + (AW+1)'(pop);
    empty_n = (wp_n == rp_n);
    full_n  = (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);

    active_n = (state_n == S_DRIVE) || (state_n == S_LATCH) || (state_n == S_HOLD);
    oe_n     = active_n ? (NREG'(1) << cur_src) : '0;
    latch_n  = (state_n == S_LATCH) ? cur_dst : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_src[wp[AW-1:0]] <= cmd_src;
      mem_dst[wp[AW-1:0]] <= cmd_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pend      <= 1'b0;
      cur_src   <= '0;
      cur_dst   <= '0;
      wp        <= '0;
      rp        <= '0;
      oe        <= '0;
      latch     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      cur_src   <= cur_src_n;
      cur_dst   <= cur_dst_n;
      wp        <= wp_n;
      rp        <= rp_n;
      oe        <= oe_n;
      latch     <= latch_n;
      done      <= (state_n == S_HOLD);
      err       <= err_n;
      busy      <= (state_n != S_IDLE) || pend_n || !empty_n;
      cmd_ready <= !full_n;
    end
  end

endmodule

// File: tb/tb_reg_bus_sched.sv
// Directed self-checking bench for reg_bus_sched (latency, FIFO full/back-to-back, illegal commands, reset mid-transfer).
module tb_reg_bus_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_src;
  logic [7:0] cmd_dst;
  logic [7:0] oe, latch;
  logic       busy, done, err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned dn    = 0;

`ifdef REG_BUS_SCHED_PRECHARGE_EN
  localparam int unsigned SPC = 5;
`else
  localparam int unsigned SPC = 4;
`endif

  typedef struct {
    logic [7:0]  oe;
    logic [7:0]  la;
    int unsigned cyc;
  } ev_t;
  ev_t lq[$];

  reg_bus_sched #(.NREG(8), .SW(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .oe(oe), .latch(latch),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus invariants, latch event log and done count, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (done) dn++;
      if (latch != 8'h00) begin
        lq.push_back('{oe: oe, la: latch, cyc: cyc});
        chk("inv_latch_oe", {31'd0, (oe != 8'h00) && ((latch & oe) == 8'h00)}, 32'd1);
      end
      if (!$onehot0(oe)) chk("inv_onehot0", {24'd0, oe}, 32'd0);
    end
  end

  // Single command from idle/empty: push at edge N, oe from N+2, latch N+3, done N+4.
  task automatic xfer(input string tag, input logic [2:0] s, input logic [7:0] d);
    logic [7:0] e;
    e = 8'd1 << s;
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d;
    step();
    cmd_valid = 1'b0;
    chk({tag, "_n0_busy"}, busy, 1);
    chk({tag, "_n0_oe"}, oe, 0);
    step();
    chk({tag, "_n1_oe"}, oe, 0);
    step();
    chk({tag, "_drv_oe"}, oe, e);
    chk({tag, "_drv_la"}, latch, 0);
    step();
    chk({tag, "_lat_oe"}, oe, e);
    chk({tag, "_lat_la"}, latch, d);
    chk({tag, "_lat_done"}, done, 0);
    step();
    chk({tag, "_hld_oe"}, oe, e);
    chk({tag, "_hld_la"}, latch, 0);
    chk({tag, "_hld_done"}, done, 1);
    step();
    chk({tag, "_end_oe"}, oe, 0);
    chk({tag, "_end_done"}, done, 0);
`ifdef REG_BUS_SCHED_PRECHARGE_EN
    chk({tag, "_pre_busy"}, busy, 1);
    step();
`endif
    chk({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    logic [2:0] es [6];
    logic [7:0] ed [6];
    logic [7:0] eo;
    int unsigned n;
    es = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd7};
    ed = '{8'h01, 8'h02, 8'h81, 8'h01, 8'h02, 8'h40};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0;
    #12;
    chk("rst_oe", oe, 0);
    chk("rst_latch", latch, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);

    // Basic transfer
    xfer("t1", 3'd2, 8'h10);

    // FIFO fill with valid held high, back-to-back drain
    lq.delete(); dn = 0;
    cmd_valid = 1'b1; cmd_src = es[0]; cmd_dst = ed[0];
    step();                                   // P0 push A
    cmd_src = es[1]; cmd_dst = ed[1];
    step();                                   // P1 push B, pop A
    cmd_src = es[2]; cmd_dst = ed[2];
    chk("t2_p1_ready", cmd_ready, 1);
    step();                                   // P2 push C
    cmd_src = es[3]; cmd_dst = ed[3];
    step();                                   // P3 push D
    cmd_src = es[4]; cmd_dst = ed[4];
    chk("t2_p3_ready", cmd_ready, 1);
    step();                                   // P4 push E, FIFO full
    cmd_src = es[5]; cmd_dst = ed[5];
    chk("t2_full_ready", cmd_ready, 0);
    step();                                   // P5 F blocked even if a pop occurs
`ifdef REG_BUS_SCHED_PRECHARGE_EN
    chk("t2_p5_ready", cmd_ready, 0);
`else
    chk("t2_p5_ready", cmd_ready, 1);
`endif
    n = 0;
    while (!cmd_ready && n < 10) begin
      step();
      n++;
    end
    chk("t2_ready_timeout", cmd_ready, 1);
    step();                                   // push F
    cmd_valid = 1'b0;
    chk("t2_refull_ready", cmd_ready, 0);
    n = 0;
    while (busy && n < 80) begin
      step();
      n++;
    end
    chk("t2_drain_busy", busy, 0);
    chk("t2_done_cnt", dn, 6);
    chk("t2_xfer_cnt", lq.size(), 6);
    for (int i = 0; i < 6 && i < lq.size(); i++) begin
      eo = 8'd1 << es[i];
      chk($sformatf("t2_oe_%0d", i), lq[i].oe, eo);
      chk($sformatf("t2_la_%0d", i), lq[i].la, ed[i]);
      if (i > 0) chk($sformatf("t2_spc_%0d", i), lq[i].cyc - lq[i-1].cyc, SPC);
    end

    // Illegal commands: self-latch and empty destination
    cmd_valid = 1'b1; cmd_src = 3'd1; cmd_dst = 8'h02;
    step();                                   // Q0 push X1
    cmd_src = 3'd7; cmd_dst = 8'h00;
    chk("t3_q0_err", err, 0);
    step();                                   // Q1 pop X1 (bad), push X2
    cmd_valid = 1'b0;
    chk("t3_q1_err", err, 1);
    chk("t3_q1_oe", oe, 0);
    chk("t3_q1_la", latch, 0);
    step();                                   // Q2 pop X2 (bad)
    chk("t3_q2_err", err, 1);
    chk("t3_q2_oe", oe, 0);
    chk("t3_q2_la", latch, 0);
    step();
    chk("t3_q3_err", err, 0);
    chk("t3_q3_busy", busy, 0);
    chk("t3_q3_oe", oe, 0);
    xfer("t3l", 3'd7, 8'h01);

    // Multi-destination
    xfer("t4", 3'd0, 8'hE0);

    // Reset asserted during LATCH
    dn = 0;
    cmd_valid = 1'b1; cmd_src = 3'd2; cmd_dst = 8'h08;
    step();                                   // N push
    cmd_src = 3'd3; cmd_dst = 8'h01;
    step();                                   // N+1 pop first, push second
    cmd_valid = 1'b0;
    step();
    step();
    chk("t5_pre_la", latch, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_oe", oe, 0);
    chk("t5_la", latch, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t5_post_oe_%0d", i), oe, 0);
      chk($sformatf("t5_post_busy_%0d", i), busy, 0);
    end
    chk("t5_no_done", dn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
